// File: rtl/onfi_cmd_seq.sv
// onfi_cmd_seq: ONFI CMD1 / address / CMD2 latch sequencer with
// programmable WE_x_n timing and per-target R/B wait with timeout.
module onfi_cmd_seq #(
    parameter int NUM_CE     = 2,
    parameter int DATA_W     = 8,
    parameter int MAX_ADDR   = 5,
    parameter int T_WP       = 2,
    parameter int T_WH       = 2,
    parameter int T_WB       = 4,
    parameter int RB_TIMEOUT = 1000,
    localparam int CE_W      = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CE_W-1:0]       req_ce,
    input  logic [7:0]            req_cmd1,
    input  logic [3:0]            req_naddr,
    input  logic [8*MAX_ADDR-1:0] req_addr,
    input  logic                  req_has_cmd2,
    input  logic [7:0]            req_cmd2,
    input  logic                  req_wait_rb,
    output logic                  done,
    output logic                  err,
    output logic                  timeout,
    input  logic [NUM_CE-1:0]     RB_x_n,
    output logic [NUM_CE-1:0]     CE_x_n,
    output logic                  CLE_x,
    output logic                  ALE_x,
    output logic                  WE_x_n,
    output logic                  RE_x_n,
    output logic [DATA_W-1:0]     io_out,
    output logic                  io_oe
);

    localparam int LAT  = T_WP + T_WH;
    localparam int CM1  = (LAT > T_WB) ? LAT : T_WB;
    localparam int CMAX = (CM1 > RB_TIMEOUT) ? CM1 : RB_TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, CMD1, ADDR, CMD2, WAIT_WB, WAIT_RB, DONE
    } state_t;

    state_t                  state_q, state_d, post;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              idx_q, idx_d;
    logic [CE_W-1:0]         ce_q, ce_v;
    logic [7:0]              cmd1_q, cmd2_q, byte_d;
    logic [8*MAX_ADDR-1:0]   addr_q;
    logic [3:0]              naddr_q;
    logic                    has2_q, wrb_q;
    logic [NUM_CE-1:0]       rb_s1, rb_s2, ce_n_d;
    logic                    err_d, tmo_d, lat_end, bad_ce, latch_d;

    assign RE_x_n = 1'b1;
    assign bad_ce = int'(req_ce) >= NUM_CE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        post    = wrb_q ? WAIT_WB : DONE;
        lat_end = (cnt_q == CW'(LAT - 1));
        unique case (state_q)
            IDLE: if (req_valid) begin
                cnt_d = '0;
                idx_d = '0;
                if (bad_ce) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = CMD1;
                end
            end
            CMD1: if (lat_end) begin
                cnt_d = '0;
                if (naddr_q != 4'd0) state_d = ADDR;
                else if (has2_q)     state_d = CMD2;
                else                 state_d = post;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ADDR: if (lat_end) begin
                cnt_d = '0;
                if (idx_q == naddr_q - 4'd1) begin
                    state_d = has2_q ? CMD2 : post;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            CMD2: if (lat_end) begin
                cnt_d   = '0;
                state_d = post;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_WB: if (cnt_q == CW'(T_WB - 1)) begin
                cnt_d   = '0;
                state_d = WAIT_RB;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_RB: if (rb_s2[ce_q]) begin
                state_d = DONE;
            end else if (cnt_q == CW'(RB_TIMEOUT - 1)) begin
                state_d = DONE;
                tmo_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so CMD1 shows on k+1.
    always_comb begin
        ce_v    = (state_q == IDLE) ? req_ce : ce_q;
        latch_d = (state_d == CMD1) || (state_d == ADDR) || (state_d == CMD2);
        unique case (state_d)
            CMD1:    byte_d = (state_q == IDLE) ? req_cmd1 : cmd1_q;
            ADDR:    byte_d = addr_q[idx_d*8 +: 8];
            CMD2:    byte_d = cmd2_q;
            default: byte_d = 8'h00;
        endcase
        ce_n_d = '1;
        if (latch_d || state_d == WAIT_WB || state_d == WAIT_RB) begin
            ce_n_d[ce_v] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            ce_q      <= '0;
            cmd1_q    <= '0;
            cmd2_q    <= '0;
            addr_q    <= '0;
            naddr_q   <= '0;
            has2_q    <= 1'b0;
            wrb_q     <= 1'b0;
            rb_s1     <= '0;
            rb_s2     <= '0;
            req_ready <= 1'b1;
            CE_x_n    <= '1;
            CLE_x     <= 1'b0;
            ALE_x     <= 1'b0;
            WE_x_n    <= 1'b1;
            io_oe     <= 1'b0;
            io_out    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            rb_s1 <= RB_x_n;
            rb_s2 <= rb_s1;
            if (state_q == IDLE && req_valid) begin
                ce_q    <= req_ce;
                cmd1_q  <= req_cmd1;
                cmd2_q  <= req_cmd2;
                addr_q  <= req_addr;
                naddr_q <= (req_naddr > 4'(MAX_ADDR)) ? 4'(MAX_ADDR)
                                                       : req_naddr;
                has2_q  <= req_has_cmd2;
                wrb_q   <= req_wait_rb;
            end
            req_ready <= (state_d == IDLE);
            CE_x_n    <= ce_n_d;
            CLE_x     <= (state_d == CMD1) || (state_d == CMD2);
            ALE_x     <= (state_d == ADDR);
            io_oe     <= latch_d;
            WE_x_n    <= !(latch_d && cnt_d < CW'(T_WP));
            io_out    <= DATA_W'(byte_d);
            done      <= (state_d == DONE);
            err       <= err_d;
            timeout   <= tmo_d;
        end
    end

endmodule
